// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM request arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, REFRESH} arb_state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  localparam logic [9:0] ACCESS_NUM_ONE = 10'h001;
  localparam int         STARVE_W       = 4;

  // Sub-phases of REFRESH: strobe, wait for refresh_mode, wait for idle.
  localparam logic [1:0] REF_STROBE    = 2'd0;
  localparam logic [1:0] REF_WAIT_MODE = 2'd1;
  localparam logic [1:0] REF_WAIT_IDLE = 2'd2;

endpackage

// File: rtl/sdram_arb_select.sv
// Combinational priority selector: refresh, starved B, A, then B.
module sdram_arb_select
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                select_en,
  input  logic                refresh_pending,
  input  logic                a_req,
  input  logic                b_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_a,
  output logic                grant_b,
  output logic                grant_refresh
);

  logic b_starved;
  logic access_en;

  assign b_starved     = b_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign access_en     = select_en && !refresh_pending;
  assign grant_refresh = select_en && refresh_pending;
  assign grant_b       = access_en && (b_starved || (b_req && !a_req));
  assign grant_a       = access_en && a_req && !b_starved;

endmodule

// File: rtl/sdram_request_arbiter.sv
// Serialises single-word requests from two masters onto the SDRAM controller
// handshake and slots refresh strobes between accesses.
module sdram_request_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              sdram_clock,
  input  logic              sdram_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  input  logic              refresh_req,
  output logic [ADDR_W-1:0] c_address,
  output logic [9:0]        c_access_num,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_write_request,
  output logic              c_read_request,
  output logic              c_enable_refresh,
  input  logic [DATA_W-1:0] c_data_out,
  input  logic              c_write_flag,
  input  logic              c_read_flag,
  input  logic              c_idle,
  input  logic              c_refresh_mode,
  output logic              busy
);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic                live_q, live_d;
  logic                refresh_pending_q, refresh_pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [1:0]          ref_phase_q, ref_phase_d;

  logic       grant_a, grant_b, grant_refresh;
  logic [1:0] port_req, port_ack, rdata_load;
  logic       owner_idx, owner_req, flag_hit, read_beat;

  assign port_req  = {b_req, a_req};
  assign owner_idx = (owner_q == OWN_B);
  assign owner_req = port_req[owner_idx];
  assign flag_hit  = we_q ? c_write_flag : c_read_flag;
  assign read_beat = !we_q && c_read_flag && ((state_q == REQ) || (state_q == DATA));

  sdram_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .select_en       ((state_q == IDLE) && c_idle),
    .refresh_pending (refresh_pending_q),
    .a_req           (a_req),
    .b_req           (b_req),
    .starve_cnt      (starve_q),
    .grant_a         (grant_a),
    .grant_b         (grant_b),
    .grant_refresh   (grant_refresh)
  );

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    we_d              = we_q;
    live_d            = live_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    starve_d          = starve_q;
    ref_phase_d       = ref_phase_q;
    refresh_pending_d = refresh_pending_q || refresh_req;
    data_d            = read_beat ? c_data_out : data_q;
    rdata_load        = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant_refresh) begin
          state_d           = REFRESH;
          ref_phase_d       = REF_STROBE;
          refresh_pending_d = refresh_req;
        end else if (grant_a || grant_b) begin
          state_d = REQ;
          live_d  = 1'b1;
          if (grant_b) begin
            owner_d = OWN_B;
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
          end else begin
            owner_d = OWN_A;
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
          end
          if (grant_b || !b_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      REQ: begin
        live_d = live_q && owner_req;
        if (flag_hit) state_d = DATA;
      end
      DATA: begin
        // An owner that dropped its request still lets the access finish, silently.
        live_d = live_q && owner_req;
        if (!flag_hit) begin
          state_d = DONE;
          if (live_d && !we_q) rdata_load[owner_idx] = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      REFRESH: begin
        case (ref_phase_q)
          REF_STROBE:    ref_phase_d = REF_WAIT_MODE;
          REF_WAIT_MODE: if (c_refresh_mode) ref_phase_d = REF_WAIT_IDLE;
          REF_WAIT_IDLE: if (c_idle) state_d = IDLE;
          default:       state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clock or posedge sdram_reset) begin
    if (sdram_reset) begin
      state_q           <= IDLE;
      owner_q           <= OWN_A;
      we_q              <= 1'b0;
      live_q            <= 1'b0;
      refresh_pending_q <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      data_q            <= '0;
      starve_q          <= '0;
      ref_phase_q       <= REF_STROBE;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      we_q              <= we_d;
      live_q            <= live_d;
      refresh_pending_q <= refresh_pending_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      data_q            <= data_d;
      starve_q          <= starve_d;
      ref_phase_q       <= ref_phase_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge sdram_clock or posedge sdram_reset) begin
      if (sdram_reset) begin
        rdata_q <= '0;
      end else if (rdata_load[gi]) begin
        rdata_q <= data_q;
      end
    end
    assign port_ack[gi] = (state_q == DONE) && live_q && (owner_idx == 1'(gi));
  end

  assign a_rdata          = g_port[0].rdata_q;
  assign b_rdata          = g_port[1].rdata_q;
  assign a_ack            = port_ack[0];
  assign b_ack            = port_ack[1];
  assign c_address        = addr_q;
  assign c_data_in        = wdata_q;
  assign c_access_num     = ACCESS_NUM_ONE;
  assign c_write_request  = (state_q == REQ) && we_q;
  assign c_read_request   = (state_q == REQ) && !we_q;
  assign c_enable_refresh = (state_q == REFRESH) && (ref_phase_q == REF_STROBE);
  assign busy             = (state_q != IDLE);

endmodule
